// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bits.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx #(
  parameter int CLKS_PER_BIT = 435,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(DATA_BITS + 1);

  localparam logic [BW-1:0] BAUD_TOP = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DATA_TOP = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_TOP = CW'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_par
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [CW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  assign bit_end = (baud_q == BAUD_TOP);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          state_d = S_START;
          shift_d = tx_data;
          baud_d  = '0;
          bit_d   = '0;
`ifdef UART_TX_PARITY_EN
          par_d   = (^tx_data) ^ 1'(PARITY_ODD);
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == DATA_TOP) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == STOP_TOP) begin
            bit_d   = '0;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Line and ready are registered from the next state so they switch
  // on the same edge as the FSM.
  always_comb begin
    tx_d    = 1'b1;
    ready_d = (state_d == S_IDLE);
    unique case (1'b1)
      (state_d == S_START): tx_d = 1'b0;
      (state_d == S_DATA):  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      (state_d == S_PARITY): tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign tx_busy  = ~ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: driver queues expected frames,
// a line monitor decodes tx and checks bits, timing and ready.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int PODD = 0;
  localparam int LIM  = 20000;

  typedef struct {
    logic [7:0] d;
    int         gap;
  } item_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       sel;
  logic       tx1, rdy1, busy1;
  logic       tx2, rdy2, busy2;
  logic       v1, v2, m_tx, m_rdy, m_busy;

  item_t q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  bit    mon_en = 1'b0;
  bit    mon_busy = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign v1     = tx_valid & ~sel;
  assign v2     = tx_valid & sel;
  assign m_tx   = sel ? tx2 : tx1;
  assign m_rdy  = sel ? rdy2 : rdy1;
  assign m_busy = sel ? busy2 : busy1;

  uart_tx #(
    .CLKS_PER_BIT(4), .DATA_BITS(8),
    .STOP_BITS(1), .PARITY_ODD(PODD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_data(tx_data), .tx_valid(v1),
    .tx_ready(rdy1), .tx(tx1), .tx_busy(busy1)
  );

  uart_tx #(
    .CLKS_PER_BIT(435), .DATA_BITS(8),
    .STOP_BITS(2), .PARITY_ODD(PODD)
  ) dut2 (
    .clk(clk), .rst_n(rst_n),
    .tx_data(tx_data), .tx_valid(v2),
    .tx_ready(rdy2), .tx(tx2), .tx_busy(busy2)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Line monitor: detects each start bit and checks one whole frame.
  initial begin : mon
    logic        ptx, spur;
    int          fc, pfc, c, nb, berr, rerr;
    logic [7:0]  got;
    logic [15:0] expb;
    item_t       it;
    ptx = 1'b1;
    pfc = -100000;
    forever begin
      @(negedge clk);
      if (mon_en && ptx && !m_tx) begin
        mon_busy = 1'b1;
        fc = cyc;
        c  = sel ? 435 : 4;
        nb = 1 + 8 + P + (sel ? 2 : 1);
        spur = (q.size() == 0);
        if (spur) begin
          chk("unexpected_frame", 1, 0);
          it.d = 8'h00;
          it.gap = 0;
        end else begin
          it = q.pop_front();
        end
        expb = '1;
        expb[0] = 1'b0;
        expb[8:1] = it.d;
        if (P == 1) expb[9] = (^it.d) ^ 1'(PODD);
        if (!spur && it.gap != 0)
          chk("stop_gap", fc - pfc - (9 + P) * c, it.gap);
        berr = 0;
        rerr = 0;
        got = '0;
        for (int k = 0; k <= nb * c; k++) begin
          if (k > 0) @(negedge clk);
          if (k < nb * c) begin
            if (m_tx !== expb[k / c]) berr++;
            if (k % c == c / 2 && k / c >= 1 && k / c <= 8)
              got[k / c - 1] = m_tx;
            if (m_rdy !== 1'b0) rerr++;
          end else if (m_rdy !== 1'b1) begin
            rerr++;
          end
          if (m_busy !== ~m_rdy) rerr++;
        end
        if (!spur) begin
          chk("data", {24'h0, got}, {24'h0, it.d});
          chk("bit_timing", berr, 0);
          chk("ready_latency", rerr, 0);
        end
        pfc = fc;
        mon_busy = 1'b0;
      end
      ptx = m_tx;
    end
  end

  task automatic send(input logic [7:0] d, input int gap,
                      input bit push, input bit hold);
    int    n;
    item_t it;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    if (push) begin
      it.d = d;
      it.gap = gap;
      q.push_back(it);
    end
    n = 0;
    while (!m_rdy && n < LIM) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIM) chk("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((q.size() != 0 || mon_busy || !m_rdy) && n < LIM);
    if (n >= LIM) chk("idle_timeout", 1, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin : main
    int hi;
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    sel      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'h0, tx1}, 1);
    chk("rst_ready", {31'h0, rdy1}, 1);
    chk("rst_busy", {31'h0, busy1}, 0);
    chk("rst_ready2", {31'h0, rdy2}, 1);
    rst_n = 1'b1;

    send(8'h5A, 0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    chk("mid_frame_busy", {31'h0, busy1}, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_tx", {31'h0, tx1}, 1);
    chk("abort_ready", {31'h0, rdy1}, 1);
    @(negedge clk);
    rst_n = 1'b1;
    hi = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx1 && rdy1) hi++;
    end
    chk("post_reset_idle", hi, 60);
    mon_en = 1'b1;

    send(8'hA5, 0, 1'b1, 1'b0);
    wait_idle();

    send(8'h00, 0, 1'b1, 1'b1);
    send(8'hFF, 5, 1'b1, 1'b0);
    wait_idle();

    send(8'h5A, 0, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_idle();
    repeat (60) @(negedge clk);

    sel = 1'b1;
    repeat (3) @(negedge clk);
    send(8'h55, 0, 1'b1, 1'b0);
    wait_idle();
    repeat (20) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
